// File: rtl/enigma_pkg.sv
// enigma_pkg: shared definitions for the Enigma rotor datapath.
//   ENIGMA_N / ENIGMA_W : default alphabet size and symbol width
//   sym_t               : default-width symbol type
//   mod_add / mod_sub   : modular add/sub for operands already in [0, n)
//   NOTCH_I..NOTCH_V    : turnover positions of the historical rotors I-V
package enigma_pkg;

  localparam int ENIGMA_N = 26;
  localparam int ENIGMA_W = 5;

  typedef logic [ENIGMA_W-1:0] sym_t;

  // Turnover positions: Q, E, V, J, Z.
  localparam sym_t NOTCH_I   = 5'd16;
  localparam sym_t NOTCH_II  = 5'd4;
  localparam sym_t NOTCH_III = 5'd21;
  localparam sym_t NOTCH_IV  = 5'd9;
  localparam sym_t NOTCH_V   = 5'd25;

  // The word is wider than any symbol, so a+b never overflows. Callers
  // truncate the result back to their own symbol width.
  typedef logic [15:0] mword_t;

  function automatic mword_t mod_add(mword_t a, mword_t b, mword_t n);
    mword_t s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

  function automatic mword_t mod_sub(mword_t a, mword_t b, mword_t n);
    return (a < b) ? a - b + n : a - b;
  endfunction

endpackage

// File: rtl/enigma_wiring_ram.sv
// enigma_wiring_ram: rotor wiring table pair (forward + inverse).
//   i_clk, i_rst_n          : clock, async active-low reset (tables -> identity)
//   i_we, i_waddr, i_wdata  : one write updates fwd[waddr]=wdata and
//                             inv[wdata]=waddr; dropped if either is >= N
//   i_fwd_addr / o_fwd_data : combinational forward read
//   i_inv_addr / o_inv_data : combinational inverse read
// Out-of-range read addresses return the address itself.
module enigma_wiring_ram #(
  parameter int N = 26,
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_we,
  input  logic [W-1:0] i_waddr,
  input  logic [W-1:0] i_wdata,
  input  logic [W-1:0] i_fwd_addr,
  output logic [W-1:0] o_fwd_data,
  input  logic [W-1:0] i_inv_addr,
  output logic [W-1:0] o_inv_data
);

  localparam int       AW = $clog2(N);
  localparam logic [W:0] NL = (W+1)'(N);

  logic [W-1:0] r_fwd [N];
  logic [W-1:0] r_inv [N];
  logic         w_wr_ok;

  assign w_wr_ok = i_we && ({1'b0, i_waddr} < NL) && ({1'b0, i_wdata} < NL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_fwd[i] <= W'(i);
        r_inv[i] <= W'(i);
      end
    end else if (w_wr_ok) begin
      r_fwd[AW'(i_waddr)] <= i_wdata;
      r_inv[AW'(i_wdata)] <= i_waddr;
    end
  end

  assign o_fwd_data = ({1'b0, i_fwd_addr} < NL) ? r_fwd[AW'(i_fwd_addr)] : i_fwd_addr;
  assign o_inv_data = ({1'b0, i_inv_addr} < NL) ? r_inv[AW'(i_inv_addr)] : i_inv_addr;

endmodule

// File: rtl/enigma_rotor_stage.sv
// enigma_rotor_stage: one clocked Enigma rotor, chainable into a stack.
//   i_clk, i_rst_n                   : clock, async active-low reset
//   i_in_valid/o_in_ready/i_in_data/i_in_rev : input symbol handshake
//   o_out_valid/i_out_ready/o_out_data/o_out_rev/o_out_err : one-entry
//                                      output register, 1-cycle latency
//   i_step_strobe, i_step_in, o_carry_out : stepping and turnover carry
//   i_pos_load/i_pos_value, i_ring_load/i_ring_value : setup loads
//   i_cfg_we/i_cfg_addr/i_cfg_data   : wiring writes (inverse auto-built)
//   o_pos                            : current position
// Build option: ENIGMA_DOUBLE_STEP_EN lets the rotor step off its own
// notch (middle-rotor double stepping).
// N must not exceed 2**W.
module enigma_rotor_stage
  import enigma_pkg::*;
#(
  parameter int N         = ENIGMA_N,
  parameter int W         = ENIGMA_W,
  parameter int NOTCH     = 16,
  parameter int RESET_POS = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data,
  input  logic         i_in_rev,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data,
  output logic         o_out_rev,
  output logic         o_out_err,
  input  logic         i_step_strobe,
  input  logic         i_step_in,
  output logic         o_carry_out,
  input  logic         i_pos_load,
  input  logic [W-1:0] i_pos_value,
  input  logic         i_ring_load,
  input  logic [W-1:0] i_ring_value,
  input  logic         i_cfg_we,
  input  logic [W-1:0] i_cfg_addr,
  input  logic [W-1:0] i_cfg_data,
  output logic [W-1:0] o_pos
);

  localparam logic [W:0]   NL      = (W+1)'(N);
  localparam mword_t       NM      = mword_t'(N);
  localparam logic [W-1:0] NOTCH_W = W'(NOTCH);

  logic [W-1:0] r_pos, r_ring;
  logic         r_out_valid, r_out_rev, r_out_err;
  logic [W-1:0] r_out_data;

  logic         w_accept, w_err, w_step;
  mword_t       w_off;
  logic [W-1:0] w_idx, w_fwd, w_inv, w_res;

  assign o_in_ready  = !r_out_valid || i_out_ready;
  assign w_accept    = i_in_valid && o_in_ready;
  assign o_carry_out = (r_pos == NOTCH_W);
  assign o_pos       = r_pos;

`ifdef ENIGMA_DOUBLE_STEP_EN
  assign w_step = i_step_strobe && (i_step_in || o_carry_out);
`else
  assign w_step = i_step_strobe && i_step_in;
`endif

  // Contact offset seen by the wiring; uses pre-step pos of this cycle.
  assign w_off = mod_sub(mword_t'(r_pos), mword_t'(r_ring), NM);
  assign w_idx = W'(mod_add(mword_t'(i_in_data), w_off, NM));
  assign w_err = ({1'b0, i_in_data} >= NL);
  assign w_res = W'(mod_sub(mword_t'(i_in_rev ? w_inv : w_fwd), w_off, NM));

  enigma_wiring_ram #(.N(N), .W(W)) u_wiring (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_we       (i_cfg_we),
    .i_waddr    (i_cfg_addr),
    .i_wdata    (i_cfg_data),
    .i_fwd_addr (w_idx),
    .o_fwd_data (w_fwd),
    .i_inv_addr (w_idx),
    .o_inv_data (w_inv)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos  <= W'(RESET_POS);
      r_ring <= '0;
    end else begin
      if (i_pos_load)  r_pos  <= i_pos_value;
      else if (w_step) r_pos  <= W'(mod_add(mword_t'(r_pos), mword_t'(1), NM));
      if (i_ring_load) r_ring <= i_ring_value;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_rev   <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_err ? i_in_data : w_res;
      r_out_rev   <= i_in_rev;
      r_out_err   <= w_err;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_rev   = r_out_rev;
  assign o_out_err   = r_out_err;

endmodule

// File: tb/tb_enigma_rotor_stage.sv
module tb_enigma_rotor_stage;

  localparam int N = 26, W = 5, NOTCH = 16, RESET_POS = 0;
`ifdef ENIGMA_DOUBLE_STEP_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b1;
  logic in_valid = 0, in_rev = 0, out_ready = 1, step_strobe = 0, step_in = 0;
  logic pos_load = 0, ring_load = 0, cfg_we = 0;
  logic [W-1:0] in_data = '0, pos_value = '0, ring_value = '0, cfg_addr = '0, cfg_data = '0;
  logic in_ready, out_valid, out_rev, out_err, carry_out;
  logic [W-1:0] out_data, pos;

  always #5 clk = ~clk;

  enigma_rotor_stage #(.N(N), .W(W), .NOTCH(NOTCH), .RESET_POS(RESET_POS)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data), .i_in_rev(in_rev),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_rev(out_rev), .o_out_err(out_err),
    .i_step_strobe(step_strobe), .i_step_in(step_in), .o_carry_out(carry_out),
    .i_pos_load(pos_load), .i_pos_value(pos_value),
    .i_ring_load(ring_load), .i_ring_value(ring_value),
    .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data),
    .o_pos(pos)
  );

  typedef struct { logic [W-1:0] data; logic rev; logic err; } exp_t;
  exp_t scb[$];
  int checks = 0, failures = 0;

  // Reference state: rotor as an abstract permutation plus position/ring.
  int m_fwd[N], m_inv[N];
  int m_pos, m_ring;
  bit m_occ;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin m_fwd[i] = i; m_inv[i] = i; end
    m_pos = RESET_POS; m_ring = 0; m_occ = 0;
  endfunction

  function automatic exp_t xlate(int d, bit rev);
    exp_t e;
    int off, idx, m;
    e.rev = rev;
    if (d >= N) begin
      e.data = W'(d); e.err = 1'b1;
    end else begin
      off = (m_pos - m_ring + N) % N;
      idx = (d + off) % N;
      m = rev ? m_inv[idx] : m_fwd[idx];
      e.data = W'((m - off + N) % N); e.err = 1'b0;
    end
    return e;
  endfunction

  // One clock: predict from inputs set before the edge, then advance.
  task automatic tick();
    bit acc, stp;
    @(negedge clk);
    if (!rst_n) begin
      model_reset();
      scb.delete();
    end else begin
      chk("out_valid", out_valid, m_occ);
      chk("in_ready", in_ready, (!m_occ || out_ready));
      chk("pos", pos, m_pos);
      chk("carry_out", carry_out, (m_pos == NOTCH));
      acc = in_valid && (!m_occ || out_ready);
      if (acc) scb.push_back(xlate(in_data, in_rev));
      m_occ = acc ? 1'b1 : (out_ready ? 1'b0 : m_occ);
      stp = step_strobe && (step_in || (DS && m_pos == NOTCH));
      if (pos_load) m_pos = pos_value;
      else if (stp) m_pos = (m_pos + 1) % N;
      if (ring_load) m_ring = ring_value;
      if (cfg_we && cfg_addr < N && cfg_data < N) begin
        m_fwd[cfg_addr] = cfg_data;
        m_inv[cfg_data] = cfg_addr;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send(int d, bit r);
    in_valid = 1; in_data = W'(d); in_rev = r;
    tick();
    in_valid = 0;
  endtask

  task automatic cfg(int a, int d);
    cfg_we = 1; cfg_addr = W'(a); cfg_data = W'(d);
    tick();
    cfg_we = 0;
  endtask

  task automatic load_pos(int v);
    pos_load = 1; pos_value = W'(v);
    tick();
    pos_load = 0;
  endtask

  // Monitor: pop once per presented result, then require it held until taken.
  initial begin : monitor
    bit seen;
    exp_t e;
    logic [W-1:0] hd;
    logic hr, he;
    seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) seen = 0;
      else if (out_valid) begin
        if (!seen) begin
          if (scb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_out actual=%0d expected=none", out_data);
          end else begin
            e = scb.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_rev", out_rev, e.rev);
            chk("out_err", out_err, e.err);
          end
          seen = 1; hd = out_data; hr = out_rev; he = out_err;
        end else begin
          chk("hold_data", out_data, hd);
          chk("hold_rev", out_rev, hr);
          chk("hold_err", out_err, he);
        end
        if (out_ready) seen = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int perm[N];
    model_reset();
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_rev", out_rev, 0);
    chk("rst_pos", pos, RESET_POS);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1;
    tick();

    // Identity pass-through, 1-cycle latency.
    out_ready = 1;
    send(7, 0);
    chk("tp_id7_valid", out_valid, 1);
    chk("tp_id7_data", out_data, 7);
    chk("tp_id7_err", out_err, 0);
    tick();

    // Partial wiring, offset translation.
    cfg(0, 6); cfg(1, 11);
    load_pos(1);
    send(0, 0);
    chk("tp_fwd10", out_data, 10);
    load_pos(0);
    send(6, 1);
    chk("tp_rev0", out_data, 0);
    cfg(0, 0); cfg(1, 1); cfg(6, 6); cfg(11, 11);

    // Wrap and load priority.
    load_pos(25);
    step_strobe = 1; step_in = 1;
    tick();
    chk("tp_wrap", pos, 0);
    pos_load = 1; pos_value = 3;
    tick();
    pos_load = 0; step_strobe = 0; step_in = 0;
    chk("tp_load_prio", pos, 3);

    // Notch carry and (optional) double step.
    load_pos(16);
    chk("tp_carry", carry_out, 1);
    step_strobe = 1; step_in = 0;
    tick();
    step_strobe = 0;
    chk("tp_notch_step", pos, DS ? 17 : 16);

    // Backpressure: result held, input stalled, then same-cycle accept.
    out_ready = 0;
    send(2, 0);
    in_valid = 1; in_data = 5; in_rev = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold2", out_data, 2);
    end
    out_ready = 1;
    tick();
    in_valid = 0;
    chk("bp_next5", out_data, 5);
    tick();

    // Out-of-range symbol.
    send(27, 0);
    chk("tp_err_data", out_data, 27);
    chk("tp_err_flag", out_err, 1);
    tick();

    // Random permutation, then randomized traffic and control.
    for (int i = 0; i < N; i++) perm[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < N; i++) cfg(i, perm[i]);
    ring_load = 1; ring_value = W'($urandom_range(N - 1, 0));
    tick();
    ring_load = 0;

    for (int c = 0; c < 500; c++) begin
      in_valid    = ($urandom % 4) != 0;
      in_data     = (($urandom % 8) == 0) ? W'($urandom_range(31, N)) : W'($urandom_range(N - 1, 0));
      in_rev      = $urandom % 2;
      out_ready   = ($urandom % 4) != 0;
      step_strobe = ($urandom % 3) == 0;
      step_in     = $urandom % 2;
      pos_load    = ($urandom % 16) == 0;
      pos_value   = W'($urandom_range(N - 1, 0));
      ring_load   = ($urandom % 16) == 0;
      ring_value  = W'($urandom_range(N - 1, 0));
      cfg_we      = ($urandom % 32) == 0;
      cfg_addr    = W'($urandom_range(31, 0));
      cfg_data    = W'($urandom_range(31, 0));
      tick();
    end
    in_valid = 0; step_strobe = 0; pos_load = 0; ring_load = 0; cfg_we = 0;
    out_ready = 1;
    repeat (3) tick();

    // Mid-transfer reset drops the pending result and restores identity.
    out_ready = 0;
    send(4, 0);
    rst_n = 0;
    #2;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_pos", pos, RESET_POS);
    tick();
    rst_n = 1;
    out_ready = 1;
    tick();
    send(9, 0);
    chk("post_rst_fwd9", out_data, 9);
    send(4, 1);
    chk("post_rst_rev4", out_data, 4);
    repeat (2) tick();

    chk("scb_drained", scb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enigma_rotor_stage.md
Name: enigma_rotor_stage

Overview:
- Parametrised, clocked Enigma rotor for the cipher datapath.
- Registered rotor position and ring setting, and runtime-loadable wiring with an auto-built inverse table.
- Forward and reverse substitution, with a valid/ready handshake and a one-entry output register.
- Stepping control with turnover carry, so N instances chain into a full rotor stack between plugboard and reflector.

Parameters:
- N, 26: alphabet size.
- W, 5: symbol width; require N <= 2**W.
- NOTCH, 16: position at which carry_out asserts (16 = 'Q').
- RESET_POS, 0: position after reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  stage can accept an input symbol.
- in_data  in  W  input symbol.
- in_rev  in  1  0 = forward path (toward reflector); 1 = reverse path.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  W  substituted symbol.
- out_rev  out  1  in_rev carried with the symbol.
- out_err  out  1  input symbol was >= N.
- step_strobe  in  1  one pulse per keypress.
- step_in  in  1  carry from the faster neighbour; tie to 1 on the fastest rotor.
- carry_out  out  1  combinational: pos == NOTCH.
- pos_load  in  1  load pos from pos_value.
- pos_value  in  W  new position.
- ring_load  in  1  load ring from ring_value.
- ring_value  in  W  new ring setting.
- cfg_we  in  1  wiring write enable.
- cfg_addr  in  W  wiring index.
- cfg_data  in  W  wiring value.
- pos  out  W  current position, for display.

Behaviour:
- Reset (async, rst_n low):
  - pos = RESET_POS, ring = 0.
  - fwd[i] = inv[i] = i (identity).
  - out_valid = 0, out_data = 0, out_rev = 0, out_err = 0.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept when in_valid && in_ready; the result appears in the output register on the next edge, so latency is 1 cycle.
  - out_data, out_rev and out_err hold stable while out_valid && !out_ready.
  - Full throughput when out_ready stays high.
- Arithmetic: all modular ops on W+1 bits. add(a,b) = a+b, minus N if >= N. sub(a,b) = a-b, plus N if a < b.
- Translation uses pos, ring and tables as registered in the accept cycle, i.e. pre-step values.
  - Let off = sub(pos, ring).
  - Forward: out = sub(fwd[add(in, off)], off).
  - Reverse: out = sub(inv[add(in, off)], off).
- Out-of-range input (in_data >= N): out_data = in_data, out_err = 1, no table access. Otherwise out_err = 0.
- Stepping: on step_strobe && step_in, pos = add(pos, 1), so N-1 wraps to 0.
- Control priority in one cycle: pos_load > step.
  - ring_load is independent of pos_load and step.
  - A step and an accept in the same cycle: translation uses the old pos.
- Wiring writes (cfg_we):
  - fwd[cfg_addr] = cfg_data and inv[cfg_data] = cfg_addr in the same edge.
  - Ignored if cfg_addr >= N or cfg_data >= N.
  - The writer is responsible for loading a permutation; a non-permutation gives undefined reverse results.
  - Takes effect for inputs accepted in following cycles.
- Mid-operation reset: a pending output is discarded and out_valid = 0 immediately.

Optional Feature:
- Macro: ENIGMA_DOUBLE_STEP_EN.
- Defined: the step condition becomes step_strobe && (step_in || carry_out). The rotor also advances itself off its own notch, which is historical middle-rotor double stepping.
- Undefined: the step condition is step_strobe && step_in only; carry_out stays combinational in both builds.

Decomposition:
- Package enigma_pkg holds:
  - N and W defaults.
  - Symbol typedef.
  - mod_add / mod_sub functions.
  - Named notch constants for rotors I–V.
- One sub-module, enigma_wiring_ram: dual table (fwd + inv) with a single write port and two combinational read ports, identity on reset.
- Stepping, position/ring registers and the handshake stay in the top module.

Test Plan:
- Identity wiring, pos=0, ring=0: forward in=7 -> out_data=7, out_valid high 1 cycle after accept, out_err=0.
- Load fwd[0]=6, fwd[1]=11, pos_load 1:
  - forward in=0 -> 10 (idx 1, map 11, minus 1).
  - With pos=0, reverse in=6 -> 0.
- Stepping with pos=25, step_in=1, one step_strobe -> pos=0. Same strobe as pos_load=1 with pos_value=3 -> pos=3.
- NOTCH=16, pos=16 -> carry_out=1. step_in=0 plus strobe:
  - with ENIGMA_DOUBLE_STEP_EN defined -> pos=17.
  - without the macro -> pos stays 16.
- Backpressure: out_ready=0 after accepting in=2 -> in_ready=0, out_data held for 5 cycles. Raise out_ready -> next input accepted the same cycle.
- in_data=27 -> out_data=27, out_err=1. rst_n low mid-transfer -> out_valid=0 asynchronously and tables return to identity.
